// File: rtl/mbb_pkg.sv
// Shared types and constants for the multiplier block buffer.
// Product signedness is selected by MBB_SIGNED_EN in mbb_mult_pipe.
package mbb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        FULL,
        READ
    } mbb_state_t;

    localparam int PIPE_MIN = 1;
    localparam int PIPE_MAX = 4;

    function automatic int clamp_pipe(input int p);
        if (p < PIPE_MIN) return PIPE_MIN;
        if (p > PIPE_MAX) return PIPE_MAX;
        return p;
    endfunction

endpackage

// File: rtl/mbb_mult_pipe.sv
// PIPE-stage multiplier with a valid bit travelling alongside the product.
// MBB_SIGNED_EN selects two's-complement operands; default is unsigned.
module mbb_mult_pipe
    import mbb_pkg::*;
#(
    parameter int OPW  = 16,
    parameter int PIPE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [OPW-1:0]   op_a,
    input  logic [OPW-1:0]   op_b,
    output logic             valid_out,
    output logic [2*OPW-1:0] product
);

    localparam int PW = 2 * OPW;
    localparam int NS = clamp_pipe(PIPE);

    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] prod_q [NS];
    logic          vld_q  [NS];

    // Low PW bits of an extended multiply are exact for either signedness
`ifdef MBB_SIGNED_EN
    assign ext_a = {{OPW{op_a[OPW-1]}}, op_a};
    assign ext_b = {{OPW{op_b[OPW-1]}}, op_b};
`else
    assign ext_a = {{OPW{1'b0}}, op_a};
    assign ext_b = {{OPW{1'b0}}, op_b};
`endif

    assign prod_d = ext_a * ext_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                vld_q[i]  <= 1'b0;
                prod_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_in;
            if (valid_in) prod_q[0] <= prod_d;
            for (int i = 1; i < NS; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign valid_out = vld_q[NS-1];
    assign product   = prod_q[NS-1];

endmodule

// File: rtl/mult_block_buffer.sv
// Fills a DEPTH-entry external buffer with products, then streams it out.
// Define MBB_SIGNED_EN for signed operands and products.
module mult_block_buffer
    import mbb_pkg::*;
#(
    parameter int OPW      = 16,
    parameter int LOGDEPTH = 6,
    parameter int PIPE     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EN_mult,
    input  logic [OPW-1:0]        mult_input0,
    input  logic [OPW-1:0]        mult_input1,
    output logic                  RDY_mult,
    output logic                  EN_writeMem,
    output logic [LOGDEPTH-1:0]   writeMem_addr,
    output logic [2*OPW-1:0]      writeMem_val,
    input  logic                  EN_blockRead,
    output logic                  EN_readMem,
    output logic [LOGDEPTH-1:0]   readMem_addr,
    input  logic [2*OPW-1:0]      readMem_val,
    output logic                  VALID_memVal,
    output logic [2*OPW-1:0]      memVal_data,
    output logic [LOGDEPTH:0]     fill_count
);

    localparam logic [LOGDEPTH:0] LAST = {1'b0, {LOGDEPTH{1'b1}}};

    mbb_state_t          state;
    logic [LOGDEPTH:0]   acc_cnt;
    logic [LOGDEPTH:0]   fill_q;
    logic [LOGDEPTH-1:0] rd_addr_q;
    logic                rd_en_q;
    logic                val_q;
    logic                accept;
    logic                wr_en;

    assign RDY_mult = ~rst & ((state == IDLE) | (state == FILL));
    assign accept   = EN_mult & RDY_mult;

    mbb_mult_pipe #(
        .OPW  (OPW),
        .PIPE (PIPE)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (accept),
        .op_a      (mult_input0),
        .op_b      (mult_input1),
        .valid_out (wr_en),
        .product   (writeMem_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            fill_q    <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            val_q     <= 1'b0;
        end else begin
            val_q <= rd_en_q;
            if (wr_en) fill_q <= fill_q + 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc_cnt <= {{LOGDEPTH{1'b0}}, 1'b1};
                        state   <= FILL;
                    end else begin
                        acc_cnt <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == LAST) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_en && fill_q == LAST) state <= FULL;
                end
                FULL: begin
                    if (EN_blockRead) begin
                        state     <= READ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                READ: begin
                    if (rd_en_q) begin
                        if (&rd_addr_q) begin
                            rd_en_q   <= 1'b0;
                            rd_addr_q <= '0;
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                    // Final read data is on the bus this cycle
                    if (val_q && !rd_en_q) begin
                        state   <= IDLE;
                        fill_q  <= '0;
                        acc_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign EN_writeMem   = wr_en;
    assign writeMem_addr = fill_q[LOGDEPTH-1:0];
    assign EN_readMem    = rd_en_q;
    assign readMem_addr  = rd_addr_q;
    assign VALID_memVal  = val_q;
    assign memVal_data   = val_q ? readMem_val : '0;
    assign fill_count    = fill_q;

endmodule

// File: tb/tb_mult_block_buffer.sv
// Directed bench for mult_block_buffer with a behavioural buffer RAM.
// Expected products follow MBB_SIGNED_EN when the bench is built with it.
module tb_mult_block_buffer;

    localparam int OPW      = 16;
    localparam int LOGDEPTH = 6;
    localparam int PIPE     = 2;
    localparam int DEPTH    = 64;
    localparam int PW       = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                EN_mult;
    logic [OPW-1:0]      mult_input0;
    logic [OPW-1:0]      mult_input1;
    logic                RDY_mult;
    logic                EN_writeMem;
    logic [LOGDEPTH-1:0] writeMem_addr;
    logic [PW-1:0]       writeMem_val;
    logic                EN_blockRead;
    logic                EN_readMem;
    logic [LOGDEPTH-1:0] readMem_addr;
    logic [PW-1:0]       readMem_val;
    logic                VALID_memVal;
    logic [PW-1:0]       memVal_data;
    logic [LOGDEPTH:0]   fill_count;

    logic [PW-1:0] mem [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    mult_block_buffer #(
        .OPW      (OPW),
        .LOGDEPTH (LOGDEPTH),
        .PIPE     (PIPE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .EN_mult       (EN_mult),
        .mult_input0   (mult_input0),
        .mult_input1   (mult_input1),
        .RDY_mult      (RDY_mult),
        .EN_writeMem   (EN_writeMem),
        .writeMem_addr (writeMem_addr),
        .writeMem_val  (writeMem_val),
        .EN_blockRead  (EN_blockRead),
        .EN_readMem    (EN_readMem),
        .readMem_addr  (readMem_addr),
        .readMem_val   (readMem_val),
        .VALID_memVal  (VALID_memVal),
        .memVal_data   (memVal_data),
        .fill_count    (fill_count)
    );

    always #5 clk = ~clk;

    // External RAM: one-cycle read latency
    always @(posedge clk) begin
        if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
        readMem_val <= EN_readMem ? mem[readMem_addr] : '0;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] expv(input int pat, input int i);
        if (pat == 0) return PW'(6 * i);
        return PW'((i + 100) * (i + 7));
    endfunction

    task automatic do_read(input int pat);
        for (int k = 0; k < 68; k++) begin
            chk("rd_strobe", EN_readMem, (k >= 1 && k <= 64));
            if (k >= 1 && k <= 64) chk("rd_addr", readMem_addr, k - 1);
            chk("rd_valid", VALID_memVal, (k >= 2 && k <= 65));
            if (k >= 2 && k <= 65) chk("rd_data", memVal_data, expv(pat, k - 2));
            else chk("rd_data_idle", memVal_data, 0);
            chk("rd_rdy", RDY_mult, (k >= 66));
            chk("rd_fill", fill_count, (k >= 66) ? 0 : DEPTH);
            chk("rd_no_write", EN_writeMem, 0);
            EN_blockRead = (k == 0);
            EN_mult      = (k <= 65);
            mult_input0  = 16'h00AA;
            mult_input1  = 16'h0055;
            @(negedge clk); #1;
        end
    endtask

    logic [OPW-1:0] ta [4];
    logic [OPW-1:0] tb [4];
    logic [PW-1:0]  te [4];

    initial begin
        ta = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h1234};
        tb = '{16'h0002, 16'h8000, 16'hFFFF, 16'h0010};
`ifdef MBB_SIGNED_EN
        te = '{32'hFFFFFFFE, 32'h40000000, 32'h00000001, 32'h00012340};
`else
        te = '{32'h0001FFFE, 32'h40000000, 32'hFFFE0001, 32'h00012340};
`endif
        rst          = 1'b1;
        EN_mult      = 1'b0;
        EN_blockRead = 1'b0;
        mult_input0  = '0;
        mult_input1  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy", RDY_mult, 0);
        chk("rst_wr", EN_writeMem, 0);
        chk("rst_rd", EN_readMem, 0);
        chk("rst_valid", VALID_memVal, 0);
        chk("rst_fill", fill_count, 0);
        chk("rst_data", memVal_data, 0);
        rst = 1'b0;
        #1;

        // Fill with EN_mult held high; blockRead pulses must be ignored
        for (int k = 0; k < 70; k++) begin
            chk("a_wr", EN_writeMem, (k >= 2 && k <= 65));
            if (k >= 2 && k <= 65) begin
                chk("a_addr", writeMem_addr, k - 2);
                chk("a_val", writeMem_val, expv(0, k - 2));
            end
            chk("a_no_read", EN_readMem, 0);
            if (k <= 63) chk("a_rdy_hi", RDY_mult, 1);
            else chk("a_rdy_lo", RDY_mult, 0);
            EN_mult      = 1'b1;
            mult_input0  = 16'(k * 3);
            mult_input1  = 16'd2;
            EN_blockRead = (k >= 10 && k <= 20);
            @(negedge clk); #1;
        end
        chk("a_full_fill", fill_count, DEPTH);
        chk("a_full_rdy", RDY_mult, 0);
        chk("a_full_wr", EN_writeMem, 0);

        do_read(0);

        // Fill with EN_mult toggling every other cycle
        for (int k = 0; k < 132; k++) begin
            chk("b_wr", EN_writeMem, (k % 2 == 0 && k >= 2 && k <= 128));
            if (k % 2 == 0 && k >= 2 && k <= 128) begin
                chk("b_addr", writeMem_addr, (k - 2) / 2);
                chk("b_val", writeMem_val, expv(1, (k - 2) / 2));
            end
            chk("b_rdy", RDY_mult, (k <= 126));
            chk("b_no_read", EN_readMem, 0);
            if (k == 60) chk("b_fill_mid", fill_count, 29);
            EN_mult      = (k % 2 == 0);
            mult_input0  = 16'((k / 2) + 100);
            mult_input1  = 16'((k / 2) + 7);
            EN_blockRead = (k >= 40 && k <= 50);
            @(negedge clk); #1;
        end
        chk("b_full_fill", fill_count, DEPTH);

        do_read(1);

        // Reset in the middle of a fill
        for (int k = 0; k < 32; k++) begin
            chk("c_wr", EN_writeMem, (k >= 2));
            if (k >= 2) chk("c_addr", writeMem_addr, k - 2);
            EN_mult     = 1'b1;
            mult_input0 = 16'(k * 3);
            mult_input1 = 16'd2;
            @(negedge clk); #1;
        end
        #1 rst = 1'b1;
        #1;
        chk("c_rst_wr", EN_writeMem, 0);
        chk("c_rst_addr", writeMem_addr, 0);
        chk("c_rst_val", writeMem_val, 0);
        chk("c_rst_fill", fill_count, 0);
        chk("c_rst_rdy", RDY_mult, 0);
        chk("c_rst_valid", VALID_memVal, 0);
        EN_mult = 1'b0;
        @(negedge clk); #1;
        chk("c_rst_hold_wr", EN_writeMem, 0);
        chk("c_rst_hold_fill", fill_count, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Restarted fill at address 0 with signedness-sensitive operands
        for (int k = 0; k < 8; k++) begin
            chk("d_wr", EN_writeMem, (k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                chk("d_addr", writeMem_addr, k - 2);
                chk("d_val", writeMem_val, te[k-2]);
            end
            EN_mult = (k < 4);
            if (k < 4) begin
                mult_input0 = ta[k];
                mult_input1 = tb[k];
            end
            @(negedge clk); #1;
        end
        chk("d_fill", fill_count, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_block_buffer.md
MULT_BLOCK_BUFFER -- requirements
Module: mult_block_buffer

Interface
REQ-001 SHALL have parameter OPW, default 16, operand width in bits; product width PW = 2*OPW.
REQ-002 SHALL have parameter LOGDEPTH, default 6, buffer address width; DEPTH = 2**LOGDEPTH entries.
REQ-003 SHALL have parameter PIPE, default 2, multiplier pipeline stages (legal 1..4).
REQ-004 SHALL have one clock and reset: clk is the single clock, and rst is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 EN_mult  in  1  operand pair offered this cycle.
REQ-008 mult_input0, mult_input1  in  OPW  operands.
REQ-009 RDY_mult  out  1  block accepts operands; transfer occurs when EN_mult && RDY_mult.
REQ-010 EN_writeMem  out  1  write strobe to external buffer RAM.
REQ-011 writeMem_addr  out  LOGDEPTH  write address; writeMem_val  out  PW  product written.
REQ-012 EN_blockRead  in  1  request to stream out the full buffer.
REQ-013 EN_readMem  out  1  read strobe; readMem_addr  out  LOGDEPTH; readMem_val  in  PW, valid one cycle after EN_readMem.
REQ-014 VALID_memVal  out  1  memVal_data valid; memVal_data  out  PW  streamed product.
REQ-015 fill_count  out  LOGDEPTH+1  number of products written since leaving IDLE.

Function
REQ-016 States SHALL be IDLE, FILL, DRAIN, FULL, READ.
REQ-017 IDLE: RDY_mult=1; first accepted transfer loads pipeline and moves to FILL; counters zeroed on entry.
REQ-018 FILL: RDY_mult=1 while accepted count < DEPTH; the DEPTH-th acceptance moves to DRAIN with RDY_mult=0 from the next cycle.
REQ-019 Each accepted pair SHALL produce EN_writeMem=1 exactly PIPE cycles later, writeMem_val = full PW-bit product, addresses 0,1,..,DEPTH-1 in acceptance order, no gaps from bubbles in EN_mult.
REQ-020 DRAIN: no acceptance; when write to address DEPTH-1 completes, move to FULL; fill_count=DEPTH.
REQ-021 FULL: RDY_mult=0, EN_writeMem=0; EN_blockRead=1 moves to READ next cycle.
REQ-022 READ: EN_readMem=1 for DEPTH consecutive cycles, readMem_addr 0..DEPTH-1; VALID_memVal=1 one cycle after each strobe with memVal_data=readMem_val registered-through combinationally.
REQ-023 After VALID_memVal for address DEPTH-1, return to IDLE next cycle; RDY_mult=1 in that cycle.
REQ-024 EN_blockRead SHALL be ignored outside FULL; EN_mult ignored when RDY_mult=0.
REQ-025 Address counters SHALL NOT wrap within a fill or read; a block always writes/reads exactly DEPTH entries.
REQ-026 EN_mult and EN_blockRead asserted together in FULL: read starts, operands dropped.

Reset
REQ-027 rst SHALL immediately force IDLE, clear pipeline valid bits and counters, and drive all strobes and VALID_memVal to 0, addresses and data outputs to 0, RDY_mult=0 while rst high.
REQ-028 Reset mid-FILL or mid-READ SHALL discard the partial block; no further writes or valids emitted after rst asserts.

Configuration
REQ-029 Macro MBB_SIGNED_EN defined: operands and product treated as two's-complement signed.
REQ-030 MBB_SIGNED_EN undefined: operands and product unsigned; all other behaviour identical.

Structure
REQ-031 Package mbb_pkg SHALL hold the state enum type and the PIPE range constants.
REQ-032 Multiplier pipeline SHALL be sub-module mbb_mult_pipe (operands, valid in -> product, valid out, PIPE stages); top holds FSM and counters.

Verification
REQ-033 Defaults, EN_mult held high, inputs i*3 and 2 for i=0..63 -> writes at addr i with value 6*i, first write 2 cycles after first accept, FULL after 64 writes.
REQ-034 EN_mult toggled every other cycle -> still 64 sequential addresses, no gaps, RDY_mult drops after 64th accept.
REQ-035 FULL, pulse EN_blockRead -> 64 EN_readMem strobes addr 0..63, VALID_memVal 64 cycles lagging by one, then IDLE with RDY_mult=1.
REQ-036 Signed build, 16'hFFFF x 16'h0002 -> 32'hFFFFFFFE; unsigned build -> 32'h0001FFFE.
REQ-037 rst asserted after 30 writes -> outputs zero asynchronously, next fill restarts at addr 0.
REQ-038 EN_blockRead during FILL and EN_mult during READ -> both ignored, counts unchanged.
